// File: rtl/bcd_display_driver.sv
// Captures an unsigned result, converts it to BCD with a double-dabble FSM, and scans it
// onto an active-low multiplexed 7-segment display with leading-zero blanking.
module bcd_display_driver #(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned NDIG        = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic [NDIG-1:0]  an,
    output logic [6:0]       sseg
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned BW = 4 * NDIG;

    typedef enum logic [1:0] {StIdle, StAdj, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [BW-1:0]    bcd_q;
    logic [BW-1:0]    disp_q;
    logic [BW-1:0]    bcd_adj;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    ref_q;
    logic [IW-1:0]    idx_q;
    logic [3:0]       sel_nib;
    logic             sel_blank;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Add-3 correction: each nibble stays within 4 bits, no carry between nibbles.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NDIG; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // A digit above position 0 is blank when it and every more significant nibble are zero.
    always_comb begin
        sel_nib   = disp_q[{idx_q, 2'b00} +: 4];
        sel_blank = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            sr_q    <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        sr_q    <= value;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state_q <= StAdj;
                    end
                end
                StAdj: begin
                    bcd_q   <= bcd_adj;
                    state_q <= StShift;
                end
                StShift: begin
                    {bcd_q, sr_q} <= {bcd_q[BW-2:0], sr_q, 1'b0};
                    cnt_q         <= cnt_q - 1'b1;
                    state_q       <= (cnt_q == CW'(1)) ? StDone : StAdj;
                end
                StDone: begin
                    disp_q  <= bcd_q;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ref_q <= '0;
            idx_q <= '0;
        end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_q <= '0;
            idx_q <= (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            ref_q <= ref_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            an   <= '1;
            sseg <= 7'h7F;
        end else begin
            an <= '1;
            if (!sel_blank) begin
                an[idx_q] <= 1'b0;
            end
            sseg <= sel_blank ? 7'h7F : seg7(sel_nib);
        end
    end

endmodule
